// File: rtl/pueo_trig_scheduler_if.sv
// Trigger request / issue bus between the trigger source, pueo_trig_scheduler and pueo_wrapper.
// slave = scheduler side (takes requests, issues triggers); master = source/sink side.
interface pueo_trig_scheduler_if;
    logic        trig_req_i;
    logic [15:0] trig_req_time_i;
    logic [15:0] trig_time_o;
    logic        trig_time_valid_o;
    logic [15:0] trig_num_o;

    modport slave  (input  trig_req_i, trig_req_time_i,
                    output trig_time_o, trig_time_valid_o, trig_num_o);
    modport master (output trig_req_i, trig_req_time_i,
                    input  trig_time_o, trig_time_valid_o, trig_num_o);
endinterface

// File: rtl/pueo_trig_scheduler.sv
// Trigger admission ahead of pueo_wrapper: gates requests by run state, holdoff and buffer credits.
// Optional TRIG_SCHED_STATS_EN adds a saturating dropped-request counter (dropped_o).
module pueo_trig_scheduler #(
    parameter int          NBUF        = 4,
    parameter logic [15:0] TIME_OFFSET = 16'd0
) (
    input  logic                       aclk_i,
    input  logic                       aclk_rst_i,
    input  logic                       run_rst_i,
    input  logic                       run_stop_i,
    input  logic [15:0]                holdoff_i,
    input  logic                       event_done_i,
    pueo_trig_scheduler_if.slave       trig_if,
    output logic                       busy_o,
    output logic                       running_o
`ifdef TRIG_SCHED_STATS_EN
    ,
    output logic [15:0]                dropped_o
`endif
);

    localparam logic [3:0] NBUF_L = NBUF[3:0];

    typedef enum logic {ST_IDLE, ST_RUNNING} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_credit;
    logic [3:0]  w_outstanding_nxt;
    logic [3:0]  r_outstanding;
    logic [15:0] r_holdoff_cnt;
    logic [15:0] r_next_num;
    logic        r_valid_p1;
    logic [15:0] r_time_p1;
    logic [15:0] r_num_p1;
    logic        r_busy;
    logic        r_running;

    // run_stop_i dominates run_rst_i; requests are only admitted in a quiet RUNNING cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_rst_i && !run_stop_i) w_state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (run_stop_i) w_state_nxt = ST_IDLE;
                w_accept = trig_if.trig_req_i && (r_holdoff_cnt == 16'd0) &&
                           (r_outstanding < NBUF_L) && !run_rst_i && !run_stop_i;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A credit return with nothing outstanding is a no-op rather than an underflow
    always_comb begin
        w_credit          = event_done_i && (r_outstanding != 4'd0);
        w_outstanding_nxt = r_outstanding;
        if (run_rst_i)
            w_outstanding_nxt = 4'd0;
        else if (w_accept && !w_credit)
            w_outstanding_nxt = r_outstanding + 4'd1;
        else if (!w_accept && w_credit)
            w_outstanding_nxt = r_outstanding - 4'd1;
    end

    always_ff @(posedge aclk_i) begin
        if (aclk_rst_i) begin
            r_state       <= ST_IDLE;
            r_outstanding <= 4'd0;
            r_holdoff_cnt <= 16'd0;
            r_next_num    <= 16'd0;
            r_busy        <= 1'b0;
            r_running     <= 1'b0;
            r_valid_p1    <= 1'b0;
            r_time_p1     <= 16'd0;
            r_num_p1      <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_busy        <= (w_outstanding_nxt == NBUF_L);
            r_running     <= (w_state_nxt == ST_RUNNING);

            if (run_rst_i)
                r_holdoff_cnt <= 16'd0;
            else if (w_accept)
                r_holdoff_cnt <= holdoff_i;
            else if (r_holdoff_cnt != 16'd0)
                r_holdoff_cnt <= r_holdoff_cnt - 16'd1;

            if (run_rst_i)
                r_next_num <= 16'd0;
            else if (w_accept)
                r_next_num <= r_next_num + 16'd1;

            // stage p1: issued trigger; time/num hold between pulses
            r_valid_p1 <= w_accept;
            if (w_accept) begin
                r_time_p1 <= trig_if.trig_req_time_i + TIME_OFFSET;
                r_num_p1  <= r_next_num;
            end
        end
    end

`ifdef TRIG_SCHED_STATS_EN
    logic [15:0] r_dropped;
    logic        w_reject;

    assign w_reject = (r_state == ST_RUNNING) && trig_if.trig_req_i &&
                      !run_rst_i && !run_stop_i && !w_accept;

    always_ff @(posedge aclk_i) begin
        if (aclk_rst_i || run_rst_i)
            r_dropped <= 16'd0;
        else if (w_reject)
            r_dropped <= sat_inc16(r_dropped);
    end

    assign dropped_o = r_dropped;
`endif

    assign trig_if.trig_time_valid_o = r_valid_p1;
    assign trig_if.trig_time_o       = r_time_p1;
    assign trig_if.trig_num_o        = r_num_p1;
    assign busy_o                    = r_busy;
    assign running_o                 = r_running;

endmodule

// File: tb/tb_pueo_trig_scheduler.sv
// Directed bench for pueo_trig_scheduler (NBUF=4, TIME_OFFSET=0x0010).
// Build with TRIG_SCHED_STATS_EN defined to also check dropped_o.
module tb_pueo_trig_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_rst;
    logic        run_stop;
    logic [15:0] holdoff;
    logic        event_done;
    logic        busy;
    logic        running;
`ifdef TRIG_SCHED_STATS_EN
    logic [15:0] dropped;
`endif

    int vectors     = 0;
    int miscompares = 0;

    pueo_trig_scheduler_if ifc ();

    pueo_trig_scheduler #(
        .NBUF        (4),
        .TIME_OFFSET (16'h0010)
    ) dut (
        .aclk_i       (clk),
        .aclk_rst_i   (rst),
        .run_rst_i    (run_rst),
        .run_stop_i   (run_stop),
        .holdoff_i    (holdoff),
        .event_done_i (event_done),
        .trig_if      (ifc),
        .busy_o       (busy),
        .running_o    (running)
`ifdef TRIG_SCHED_STATS_EN
        ,
        .dropped_o    (dropped)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_rst = 1'b0; run_stop = 1'b0; holdoff = 16'd0; event_done = 1'b0;
        ifc.trig_req_i = 1'b0; ifc.trig_req_time_i = 16'd0;
        step(); step();
        rst = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b0) begin
            $display("FAIL reset_valid: got %b want 0", ifc.trig_time_valid_o); miscompares++;
        end
        vectors++;
        if (ifc.trig_time_o !== 16'h0000 || ifc.trig_num_o !== 16'h0000) begin
            $display("FAIL reset_data: time %h num %h want 0000 0000", ifc.trig_time_o, ifc.trig_num_o);
            miscompares++;
        end
        vectors++;
        if (busy !== 1'b0 || running !== 1'b0) begin
            $display("FAIL reset_flags: busy %b running %b want 0 0", busy, running); miscompares++;
        end
`ifdef TRIG_SCHED_STATS_EN
        vectors++;
        if (dropped !== 16'd0) begin
            $display("FAIL reset_dropped: got %0d want 0", dropped); miscompares++;
        end
`endif
    endtask

    task automatic test_basic();
        run_rst = 1'b1; step(); run_rst = 1'b0;
        vectors++;
        if (running !== 1'b1) begin
            $display("FAIL basic_running: got %b want 1", running); miscompares++;
        end
        ifc.trig_req_i = 1'b1; ifc.trig_req_time_i = 16'h0100;
        step();
        ifc.trig_req_i = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || ifc.trig_time_o !== 16'h0110 || ifc.trig_num_o !== 16'h0000) begin
            $display("FAIL basic_issue: valid %b time %h num %h want 1 0110 0000",
                     ifc.trig_time_valid_o, ifc.trig_time_o, ifc.trig_num_o);
            miscompares++;
        end
        step();
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b0 || ifc.trig_time_o !== 16'h0110) begin
            $display("FAIL basic_pulse_hold: valid %b time %h want 0 0110", ifc.trig_time_valid_o, ifc.trig_time_o);
            miscompares++;
        end
        event_done = 1'b1; step(); event_done = 1'b0;
    endtask

    task automatic test_holdoff();
        logic exp_v;
        run_rst = 1'b1; step(); run_rst = 1'b0;
        holdoff = 16'd3;
        for (int k = 0; k < 5; k++) begin
            ifc.trig_req_i = 1'b1; ifc.trig_req_time_i = 16'(k);
            step();
            exp_v = (k == 0 || k == 4);
            vectors++;
            if (ifc.trig_time_valid_o !== exp_v) begin
                $display("FAIL holdoff_valid[%0d]: got %b want %b", k, ifc.trig_time_valid_o, exp_v);
                miscompares++;
            end
        end
        ifc.trig_req_i = 1'b0;
        holdoff = 16'd0;
        vectors++;
        if (ifc.trig_num_o !== 16'd1 || ifc.trig_time_o !== 16'h0014) begin
            $display("FAIL holdoff_second: num %h time %h want 0001 0014", ifc.trig_num_o, ifc.trig_time_o);
            miscompares++;
        end
`ifdef TRIG_SCHED_STATS_EN
        vectors++;
        if (dropped !== 16'd3) begin
            $display("FAIL holdoff_dropped: got %0d want 3", dropped); miscompares++;
        end
`endif
    endtask

    task automatic test_credits();
        run_rst = 1'b1; step(); run_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ifc.trig_req_i = 1'b1; ifc.trig_req_time_i = 16'h0020 + 16'(k);
            step();
            ifc.trig_req_i = 1'b0;
            vectors++;
            if (ifc.trig_time_valid_o !== (k < 4) || busy !== (k >= 3)) begin
                $display("FAIL credits_fill[%0d]: valid %b busy %b want %b %b",
                         k, ifc.trig_time_valid_o, busy, (k < 4), (k >= 3));
                miscompares++;
            end
            step();
        end
        event_done = 1'b1; step(); event_done = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL credits_release: busy %b want 0", busy); miscompares++;
        end
        ifc.trig_req_i = 1'b1; step(); ifc.trig_req_i = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || ifc.trig_num_o !== 16'd4 || busy !== 1'b1) begin
            $display("FAIL credits_reuse: valid %b num %h busy %b want 1 0004 1",
                     ifc.trig_time_valid_o, ifc.trig_num_o, busy);
            miscompares++;
        end
    endtask

    task automatic test_same_cycle();
        event_done = 1'b1; step(); event_done = 1'b0;
        ifc.trig_req_i = 1'b1; event_done = 1'b1; step(); event_done = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || ifc.trig_num_o !== 16'd5 || busy !== 1'b0) begin
            $display("FAIL same_cycle_accept: valid %b num %h busy %b want 1 0005 0",
                     ifc.trig_time_valid_o, ifc.trig_num_o, busy);
            miscompares++;
        end
        step();
        ifc.trig_req_i = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL same_cycle_last: valid %b busy %b want 1 1", ifc.trig_time_valid_o, busy);
            miscompares++;
        end
        run_rst = 1'b1; step(); run_rst = 1'b0;
        event_done = 1'b1; step(); event_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ifc.trig_req_i = 1'b1;
            step();
            vectors++;
            if (ifc.trig_time_valid_o !== (k < 4)) begin
                $display("FAIL no_underflow[%0d]: valid %b want %b", k, ifc.trig_time_valid_o, (k < 4));
                miscompares++;
            end
        end
        ifc.trig_req_i = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL no_underflow_busy: busy %b want 1", busy); miscompares++;
        end
    endtask

    task automatic test_run_ctrl();
        run_stop = 1'b1; step(); run_stop = 1'b0;
        vectors++;
        if (running !== 1'b0) begin
            $display("FAIL stop_running: got %b want 0", running); miscompares++;
        end
        event_done = 1'b1; ifc.trig_req_i = 1'b1; step(); event_done = 1'b0; ifc.trig_req_i = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL idle_drain: valid %b busy %b want 0 0", ifc.trig_time_valid_o, busy);
            miscompares++;
        end
        run_rst = 1'b1; step();
        ifc.trig_req_i = 1'b1; step();
        run_rst = 1'b0;
        vectors++;
        if (running !== 1'b1 || ifc.trig_time_valid_o !== 1'b0) begin
            $display("FAIL run_rst_req: running %b valid %b want 1 0", running, ifc.trig_time_valid_o);
            miscompares++;
        end
        ifc.trig_req_time_i = 16'h1234;
        step();
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || ifc.trig_num_o !== 16'd0 || busy !== 1'b0) begin
            $display("FAIL restart_num: valid %b num %h busy %b want 1 0000 0",
                     ifc.trig_time_valid_o, ifc.trig_num_o, busy);
            miscompares++;
        end
        step(); step(); step();
        ifc.trig_req_i = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL refill_busy: busy %b want 1", busy); miscompares++;
        end
        run_rst = 1'b1; run_stop = 1'b1; step(); run_rst = 1'b0; run_stop = 1'b0;
        vectors++;
        if (running !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rst_and_stop: running %b busy %b want 0 0", running, busy); miscompares++;
        end
        ifc.trig_req_i = 1'b1; step(); ifc.trig_req_i = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b0) begin
            $display("FAIL rst_and_stop_req: valid %b want 0", ifc.trig_time_valid_o); miscompares++;
        end
    endtask

    task automatic test_wrap();
        int          nvalid;
        logic [15:0] last_num;
        run_rst = 1'b1; step(); run_rst = 1'b0;
        ifc.trig_req_i = 1'b1; ifc.trig_req_time_i = 16'hFFF8;
        step();
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || ifc.trig_time_o !== 16'h0008 || ifc.trig_num_o !== 16'd0) begin
            $display("FAIL time_wrap: valid %b time %h num %h want 1 0008 0000",
                     ifc.trig_time_valid_o, ifc.trig_time_o, ifc.trig_num_o);
            miscompares++;
        end
        nvalid   = 0;
        last_num = 16'd0;
        event_done = 1'b1;
        for (int i = 1; i < 65536; i++) begin
            step();
            if (ifc.trig_time_valid_o === 1'b1) begin
                nvalid++;
                last_num = ifc.trig_num_o;
            end
        end
        vectors++;
        if (nvalid !== 65535 || last_num !== 16'hFFFF) begin
            $display("FAIL num_run: accepts %0d last %h want 65535 ffff", nvalid, last_num);
            miscompares++;
        end
        step();
        ifc.trig_req_i = 1'b0; event_done = 1'b0;
        vectors++;
        if (ifc.trig_time_valid_o !== 1'b1 || ifc.trig_num_o !== 16'd0) begin
            $display("FAIL num_wrap: valid %b num %h want 1 0000", ifc.trig_time_valid_o, ifc.trig_num_o);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_holdoff();
        test_credits();
        test_same_cycle();
        test_run_ctrl();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
